// File: rtl/fan_pwm_driver.sv
// Fan motor PWM driver: maps a 3-bit speed command to a duty target, kick-starts
// the fan from standstill, slew-limits later duty changes and updates PWM per period.
module fan_pwm_driver #(
    parameter int PWM_BITS    = 8,
    parameter int RAMP_DIV    = 16,
    parameter int KICK_CYCLES = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] fan_speed,
    output logic       fan_pwm,
    output logic [7:0] duty_current,
    output logic       fan_on,
    output logic       ramping
);

    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int KICK_W = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [KICK_W-1:0]   KICK_LAST = KICK_W'(KICK_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE,
        KICK,
        RAMP,
        HOLD
    } state_t;

    state_t              state;
    logic [2:0]          speed_q;
    logic [7:0]          target;
    logic [7:0]          duty_step;
    logic [7:0]          duty_shadow;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic [KICK_W-1:0]   kick_cnt;
    logic                pwm_compare;

    always_comb begin
        target = 8'd255;
        case (speed_q)
            3'd0:    target = 8'd0;
            3'd1:    target = 8'd64;
            3'd2:    target = 8'd128;
            3'd3:    target = 8'd192;
            default: target = 8'd255;
        endcase
    end

    // One LSB toward the target; never moves past it, so no wrap at 0 or 255.
    always_comb begin
        duty_step = duty_current;
        if (duty_current < target) begin
            duty_step = duty_current + 8'd1;
        end else if (duty_current > target) begin
            duty_step = duty_current - 8'd1;
        end
    end

    always_comb begin
        pwm_compare = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);
    end

    // The shadow only changes on the last count of a period, so no period is cut short.
    always_ff @(posedge clk) begin
        if (!reset) begin
            speed_q     <= 3'd0;
            pwm_cnt     <= '0;
            duty_shadow <= 8'd0;
        end else begin
            speed_q <= fan_speed;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == PWM_LAST) begin
                duty_shadow <= duty_current;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            duty_current <= 8'd0;
            ramp_cnt     <= '0;
            kick_cnt     <= '0;
            fan_pwm      <= 1'b0;
            fan_on       <= 1'b0;
            ramping      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fan_pwm      <= 1'b0;
                    duty_current <= 8'd0;
                    if (target != 8'd0) begin
                        state    <= KICK;
                        kick_cnt <= '0;
                        fan_on   <= 1'b1;
                    end
                end
                KICK: begin
                    if (target == 8'd0) begin
                        state   <= IDLE;
                        fan_on  <= 1'b0;
                        fan_pwm <= 1'b0;
                    end else begin
                        fan_pwm  <= 1'b1;
                        kick_cnt <= kick_cnt + KICK_W'(1);
                        if (kick_cnt == KICK_LAST) begin
                            state        <= HOLD;
                            duty_current <= target;
                        end
                    end
                end
                HOLD: begin
                    fan_pwm <= pwm_compare;
                    if (target != duty_current) begin
                        state    <= RAMP;
                        ramp_cnt <= '0;
                        ramping  <= 1'b1;
                    end
                end
                RAMP: begin
                    fan_pwm  <= pwm_compare;
                    ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + RAMP_W'(1);
                    // Leave on the same edge the final step lands, not one edge later.
                    if ((duty_current == target) ||
                        ((ramp_cnt == RAMP_LAST) && (duty_step == target))) begin
                        duty_current <= target;
                        ramping      <= 1'b0;
                        if (target == 8'd0) begin
                            state   <= IDLE;
                            fan_on  <= 1'b0;
                            fan_pwm <= 1'b0;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (ramp_cnt == RAMP_LAST) begin
                        duty_current <= duty_step;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Bench for fan_pwm_driver: fixed vector table, multi-cycle corner sequences and
// randomized speed commands, all checked every cycle against a reference model.
module tb_fan_pwm_driver;

    localparam int KICK     = 512;
    localparam int RAMP_DIV = 16;
    localparam int PERIOD   = 256;

    logic       clk;
    logic       reset;
    logic [2:0] fan_speed;
    logic       fan_pwm;
    logic [7:0] duty_current;
    logic       fan_on;
    logic       ramping;

    int n_vectors;
    int n_miscompares;

    fan_pwm_driver #(
        .PWM_BITS   (8),
        .RAMP_DIV   (RAMP_DIV),
        .KICK_CYCLES(KICK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fan_speed   (fan_speed),
        .fan_pwm     (fan_pwm),
        .duty_current(duty_current),
        .fan_on      (fan_on),
        .ramping     (ramping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase flags plus plain integer duty, period position and ages.
    int m_speed, m_duty, m_shadow, m_pos, m_kick_age, m_ramp_age;
    bit m_pwm, m_on, m_kick, m_ramp;

    function automatic int target_of(input int s);
        if (s == 0) return 0;
        if (s >= 4) return 255;
        return 64 * s;
    endfunction

    task automatic modelEdge(input bit rst_n, input int spd);
        int tgt, pos, shadow_old;
        if (!rst_n) begin
            m_speed = 0; m_duty = 0; m_shadow = 0; m_pos = 0;
            m_kick_age = 0; m_ramp_age = 0;
            m_pwm = 0; m_on = 0; m_kick = 0; m_ramp = 0;
            return;
        end
        tgt        = target_of(m_speed);
        pos        = m_pos;
        shadow_old = m_shadow;
        m_speed    = spd;
        m_pos      = (m_pos + 1) % PERIOD;
        if (pos == PERIOD - 1) m_shadow = m_duty;
        if (!m_on) begin
            m_pwm = 0;
            if (tgt != 0) begin
                m_on = 1; m_kick = 1; m_kick_age = 0;
            end
        end else if (m_kick) begin
            if (tgt == 0) begin
                m_on = 0; m_kick = 0; m_pwm = 0;
            end else begin
                m_pwm = 1;
                m_kick_age++;
                if (m_kick_age == KICK) begin
                    m_kick = 0; m_duty = tgt;
                end
            end
        end else begin
            m_pwm = (shadow_old == 255) || (pos < shadow_old);
            if (!m_ramp) begin
                if (tgt != m_duty) begin
                    m_ramp = 1; m_ramp_age = 0;
                end
            end else begin
                if (m_duty != tgt && (m_ramp_age % RAMP_DIV) == RAMP_DIV - 1)
                    m_duty += (tgt > m_duty) ? 1 : -1;
                if (m_duty == tgt) begin
                    m_ramp = 0;
                    if (tgt == 0) begin
                        m_on = 0; m_pwm = 0;
                    end
                end
                m_ramp_age++;
            end
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst_n, input int spd, input int cycles);
        int act, exp;
        reset     = rst_n;
        fan_speed = 3'(spd);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            modelEdge(rst_n, spd);
            act = (int'(fan_pwm) << 10) | (int'(fan_on) << 9) | (int'(ramping) << 8) | int'(duty_current);
            exp = (int'(m_pwm) << 10) | (int'(m_on) << 9) | (int'(m_ramp) << 8) | m_duty;
            checkOutput("model", act, exp);
        end
    endtask

    typedef struct {
        bit       rst_n;
        bit [2:0] speed;
        int       cycles;
        bit       exp_on;
        bit       exp_ramp;
        int       exp_duty;
        int       exp_pwm;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int n, cnt, bad, t, last_t, prev;
        n_vectors     = 0;
        n_miscompares = 0;
        reset         = 1'b0;
        fan_speed     = 3'd0;

        // Expected values after holding each input for the given number of cycles
        // (exp_pwm of -1 means fan_pwm is not checked at that point).
        vecs = '{
            '{1'b0, 3'd4,    3, 1'b0, 1'b0,   0,  0},
            '{1'b1, 3'd4,    1, 1'b0, 1'b0,   0,  0},
            '{1'b1, 3'd4,    1, 1'b1, 1'b0,   0,  0},
            '{1'b1, 3'd4,    1, 1'b1, 1'b0,   0,  1},
            '{1'b1, 3'd4,  510, 1'b1, 1'b0,   0,  1},
            '{1'b1, 3'd4,    1, 1'b1, 1'b0, 255,  1},
            '{1'b1, 3'd4,    1, 1'b1, 1'b0, 255,  0},
            '{1'b1, 3'd4,  253, 1'b1, 1'b0, 255,  0},
            '{1'b1, 3'd4,    1, 1'b1, 1'b0, 255,  1},
            '{1'b1, 3'd0,    1, 1'b1, 1'b0, 255,  1},
            '{1'b1, 3'd0,    1, 1'b1, 1'b1, 255,  1},
            '{1'b1, 3'd0, 4079, 1'b1, 1'b1,   1, -1},
            '{1'b1, 3'd0,    1, 1'b0, 1'b0,   0,  0},
            '{1'b1, 3'd0,  600, 1'b0, 1'b0,   0,  0},
            '{1'b1, 3'd3,    2, 1'b1, 1'b0,   0,  0},
            '{1'b1, 3'd3,   99, 1'b1, 1'b0,   0,  1},
            '{1'b1, 3'd0,    1, 1'b1, 1'b0,   0,  1},
            '{1'b1, 3'd0,    1, 1'b0, 1'b0,   0,  0},
            '{1'b1, 3'd0,   20, 1'b0, 1'b0,   0,  0}
        };

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].rst_n, int'(vecs[i].speed), vecs[i].cycles);
            checkOutput($sformatf("vec%0d_fan_on", i), int'(fan_on), int'(vecs[i].exp_on));
            checkOutput($sformatf("vec%0d_ramping", i), int'(ramping), int'(vecs[i].exp_ramp));
            checkOutput($sformatf("vec%0d_duty", i), int'(duty_current), vecs[i].exp_duty);
            if (vecs[i].exp_pwm >= 0)
                checkOutput($sformatf("vec%0d_pwm", i), int'(fan_pwm), vecs[i].exp_pwm);
        end

        // Kick from standstill at speed 2, then 50% duty.
        applyStimulus(1'b1, 2, 1);
        n = 0;
        while (!fan_pwm && n < 10) begin applyStimulus(1'b1, 2, 1); n++; end
        checkOutput("kick_rise", int'(fan_pwm), 1);
        cnt = 0;
        while (fan_pwm && cnt < 1000) begin cnt++; applyStimulus(1'b1, 2, 1); end
        checkOutput("kick_len", cnt, KICK);
        checkOutput("kick_duty", int'(duty_current), 128);
        checkOutput("kick_hold", int'(fan_on && !ramping), 1);
        applyStimulus(1'b1, 2, 300);
        cnt = 0;
        for (int c = 0; c < PERIOD; c++) begin applyStimulus(1'b1, 2, 1); cnt += int'(fan_pwm); end
        checkOutput("duty128_high", cnt, 128);

        // Ramp 128 -> 255: one LSB every RAMP_DIV cycles.
        applyStimulus(1'b1, 4, 2);
        cnt = 0; bad = 0; t = 0; last_t = 0; prev = int'(duty_current);
        while (ramping && cnt < 5000) begin
            cnt++;
            applyStimulus(1'b1, 4, 1);
            t++;
            if (int'(duty_current) != prev) begin
                if (int'(duty_current) != prev + 1 || t - last_t != RAMP_DIV) bad++;
                last_t = t;
                prev   = int'(duty_current);
            end
        end
        checkOutput("ramp_up_len", cnt, 2032);
        checkOutput("ramp_up_steps", bad, 0);
        checkOutput("ramp_up_duty", int'(duty_current), 255);
        applyStimulus(1'b1, 4, 300);
        cnt = 0;
        for (int c = 0; c < PERIOD; c++) begin applyStimulus(1'b1, 4, 1); cnt += int'(fan_pwm); end
        checkOutput("duty255_high", cnt, PERIOD);

        // Ramp 255 -> 0, then idle with no re-kick.
        applyStimulus(1'b1, 0, 2);
        cnt = 0;
        while (ramping && cnt < 6000) begin cnt++; applyStimulus(1'b1, 0, 1); end
        checkOutput("ramp_down_len", cnt, 4080);
        checkOutput("ramp_down_off", int'(fan_on), 0);
        cnt = 0;
        for (int c = 0; c < 600; c++) begin
            applyStimulus(1'b1, 0, 1);
            cnt += int'(fan_on | fan_pwm);
        end
        checkOutput("idle_no_rekick", cnt, 0);

        // Reversal mid-ramp: 64 -> 192, turn back to 64 at duty 100.
        applyStimulus(1'b1, 1, 1);
        n = 0;
        while (!(duty_current == 8'd64 && fan_on && !ramping) && n < 1000) begin
            applyStimulus(1'b1, 1, 1); n++;
        end
        checkOutput("hold64", int'(duty_current), 64);
        n = 0;
        while (duty_current != 8'd100 && n < 3000) begin applyStimulus(1'b1, 3, 1); n++; end
        checkOutput("reach100", int'(duty_current), 100);
        n = 0;
        while (duty_current == 8'd100 && n < 100) begin applyStimulus(1'b1, 1, 1); n++; end
        checkOutput("reverse_step", int'(duty_current), 99);
        n = 0;
        while (ramping && n < 2000) begin applyStimulus(1'b1, 1, 1); n++; end
        checkOutput("reverse_settle", int'(duty_current), 64);
        checkOutput("reverse_hold", int'(fan_on && !ramping), 1);

        // Speed 7 clamps to full duty.
        applyStimulus(1'b1, 7, 2);
        n = 0;
        while (ramping && n < 5000) begin applyStimulus(1'b1, 7, 1); n++; end
        checkOutput("clamp7", int'(duty_current), 255);

        // Random speed commands and occasional resets, checked by the model.
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 9) == 0)
                applyStimulus(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
            applyStimulus(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(1, 300)));
        end
        applyStimulus(1'b1, 5, 1200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/fan_pwm_driver.md
# fan_pwm_driver

Downstream actuator stage for the AC controller. Consumes the 3-bit fan speed command, maps it to an 8-bit PWM duty target, and drives a single-bit fan motor PWM output. From standstill the fan gets a full-power kick-start; after that, duty changes are slew-limited. Duty updates are applied only at PWM period boundaries, so no period is ever truncated.

## Interface
Parameters:
- PWM_BITS, 8: PWM counter width; period = 2^PWM_BITS clk cycles (256).
- RAMP_DIV, 16: clk cycles per ±1 duty step while ramping.
- KICK_CYCLES, 512: length of the full-on kick-start pulse, in clk cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (sampled on the clk rising edge).
- fan_speed  input  3  speed command: 0 = off, 1..4 = slow..fastest, 5..7 = fastest.
- fan_pwm  output  1  registered PWM drive to the fan motor.
- duty_current  output  8  current ramped duty value (pre-shadow).
- fan_on  output  1  high in KICK, RAMP and HOLD.
- ramping  output  1  high in RAMP only.

## Operation
- Input register: speed_q <= fan_speed every cycle.
- Target mapping from speed_q:
  - 0 → 0
  - 1 → 64
  - 2 → 128
  - 3 → 192
  - 4..7 → 255 (clamped)
- State machine: IDLE, KICK, RAMP, HOLD.
  - IDLE:
    - duty_current = 0; fan_pwm = 0.
    - target ≠ 0 → KICK; kick_cnt cleared.
  - KICK:
    - fan_pwm = 1 continuously; duty_current stays 0; kick_cnt increments.
    - target = 0 → IDLE on the next edge (kick aborted).
    - kick_cnt = KICK_CYCLES-1 → HOLD, with duty_current loaded directly to the target.
  - HOLD:
    - duty_current = target.
    - target ≠ duty_current → RAMP; ramp_cnt cleared.
  - RAMP:
    - ramp_cnt counts 0..RAMP_DIV-1 and wraps.
    - At ramp_cnt = RAMP_DIV-1, duty_current moves one step toward the current target (+1 or -1).
    - The target is re-evaluated every cycle, so a reversal mid-ramp changes direction at the next step with no restart.
    - duty_current = target and target ≠ 0 → HOLD.
    - duty_current = target = 0 → IDLE.
- KICK is entered only from IDLE. A nonzero target reached by ramping down does not re-kick.
- PWM generation:
  - pwm_cnt is PWM_BITS wide, free-running in every state including IDLE, wrapping 255 → 0.
  - duty_shadow <= duty_current when pwm_cnt = 255, so it takes effect from the period starting at pwm_cnt = 0.
  - In RAMP/HOLD: fan_pwm <= (duty_shadow == 255) ? 1 : (pwm_cnt < duty_shadow).
  - duty 255 is therefore always-on, not 255/256.
- Duty arithmetic is 8-bit unsigned. Steps never overshoot the target or wrap past 0/255.
- Reset (any cycle, including mid-KICK or mid-RAMP) sets on the next edge:
  - state IDLE;
  - speed_q, duty_current, duty_shadow, pwm_cnt, ramp_cnt, kick_cnt = 0;
  - fan_pwm, fan_on, ramping = 0.

## Timing
- fan_speed change sampled at edge N:
  - speed_q valid after N+1;
  - state transition at edge N+2;
  - fan_on/ramping reflect the new state after N+2.
- KICK fan_pwm goes high at edge N+3 and stays high for exactly KICK_CYCLES cycles.
- After KICK → HOLD, fan_pwm follows duty_shadow, which updates at the next pwm_cnt = 255 edge.
- Ramp rate is one duty LSB per RAMP_DIV cycles:
  - 128 → 255 takes 127×16 = 2032 cycles;
  - 255 → 0 takes 4080 cycles.
- fan_pwm is registered: one cycle after the pwm_cnt/duty_shadow compare.
- There are no handshakes: fan_speed is level-sampled every cycle. A glitch shorter than one cycle between samples is ignored.

## Test plan
- Reset with fan_speed = 4 held, reset low for 3 cycles: all outputs 0 and state IDLE during reset; KICK begins 2 cycles after release.
- IDLE, fan_speed 0→2:
  - fan_pwm high for exactly 512 cycles;
  - then duty_current = 128 and HOLD;
  - from the next period, fan_pwm high 128 of every 256 cycles.
- HOLD at 128, fan_speed 2→4:
  - ramping = 1 for 2032 cycles while duty_current steps +1 every 16 cycles to 255;
  - then HOLD with fan_pwm constantly 1.
- HOLD at 255, fan_speed → 0:
  - duty_current ramps to 0 in 4080 cycles, then IDLE;
  - fan_on = 0, fan_pwm = 0, no re-kick.
- fan_speed 0→3, then → 0 at cycle 100 of KICK: IDLE two edges later; fan_pwm low, duty_current stays 0.
- Mid-ramp reversal and clamp:
  - ramping 64→192, switch fan_speed to 1 at duty_current = 100: duty reverses at the next step and settles at 64 in HOLD;
  - fan_speed = 7: target is 255.
